phoenix_vc_buffer: RTL and testbench

//  Next-generation Phoenix router input buffer. Stores flits per virtual channel (VC) in private FIFOs.

---
 rtl/phoenix_vc_buffer_if.sv | 37 +++
 rtl/phoenix_vc_buffer.sv | 178 +++++++++++++++++
 tb/tb_phoenix_vc_buffer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phoenix_vc_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : phoenix_vc_buffer_if
// Description : Link-side, switch-control and crossbar signals of the Phoenix
//               VC input buffer, grouped into one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface phoenix_vc_buffer_if #(
   parameter int FLIT_W = 16,
   parameter int NUM_VC = 2
);
   localparam int c_VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   logic              i_rx;
   logic [c_VC_W-1:0] i_rx_vc;
   logic [FLIT_W-1:0] i_data;
   logic [NUM_VC-1:0] o_credit;
   logic              o_h;
   logic              i_ack_h;
   logic              o_data_av;
   logic [FLIT_W-1:0] o_data;
   logic [c_VC_W-1:0] o_vc;
   logic              i_data_ack;
   logic              o_sender;
   logic [NUM_VC-1:0] o_ovf;

   modport slave (
      input  i_rx, i_rx_vc, i_data, i_ack_h, i_data_ack,
      output o_credit, o_h, o_data_av, o_data, o_vc, o_sender, o_ovf
   );

   modport master (
      output i_rx, i_rx_vc, i_data, i_ack_h, i_data_ack,
      input  o_credit, o_h, o_data_av, o_data, o_vc, o_sender, o_ovf
   );
endinterface
`default_nettype wire

// File: rtl/phoenix_vc_buffer.sv
`default_nettype none
// ============================================================================
// Module      : phoenix_vc_buffer
// Description : Per-VC flit FIFOs with round-robin packet arbitration that
//               streams one whole packet at a time toward the crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
module phoenix_vc_buffer #(
   parameter int FLIT_W = 16,
   parameter int DEPTH  = 4,
   parameter int NUM_VC = 2
) (
   input logic                i_clk,
   input logic                i_rst,
   phoenix_vc_buffer_if.slave bus
);
   localparam int c_VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t             r_state;
   logic [c_VC_W-1:0]  r_vc;
   logic [c_VC_W-1:0]  r_rr;
   logic               r_h;
   logic               r_sender;
   logic [1:0]         r_idx;
   logic [FLIT_W-1:0]  r_rem;
   logic [FLIT_W-1:0]  r_mem    [NUM_VC][DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr [NUM_VC];
   logic [c_PTR_W-1:0] r_rd_ptr [NUM_VC];
   logic [c_CNT_W-1:0] r_count  [NUM_VC];
   logic [NUM_VC-1:0]  r_ovf;

   logic [NUM_VC-1:0]  w_full;
   logic [NUM_VC-1:0]  w_empty;
   logic [NUM_VC-1:0]  w_push;
   logic [NUM_VC-1:0]  w_pop;
   logic [NUM_VC-1:0]  w_ovf_set;
   logic [FLIT_W-1:0]  w_head;
   logic               w_data_av;
   logic               w_accept;
   logic               w_last;
   logic               w_pick_ok;
   logic [c_VC_W-1:0]  w_pick;

   assign w_head    = r_mem[r_vc][r_rd_ptr[r_vc]];
   assign w_data_av = r_sender && !w_empty[r_vc];
   assign w_accept  = w_data_av && bus.i_data_ack;
   assign w_last    = w_accept && (((r_idx == 2'd1) && (w_head == '0)) ||
                                   ((r_idx == 2'd2) && (r_rem == FLIT_W'(1))));

   // Fullness is judged on the registered count, so a pop in the same cycle
   // does not make room for an incoming flit.
   always_comb begin
      w_full    = '0;
      w_empty   = '0;
      w_push    = '0;
      w_pop     = '0;
      w_ovf_set = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         w_full[v]    = (r_count[v] == c_CNT_W'(DEPTH));
         w_empty[v]   = (r_count[v] == '0);
         w_push[v]    = bus.i_rx && (int'(bus.i_rx_vc) == v) && !w_full[v];
         w_ovf_set[v] = bus.i_rx && (int'(bus.i_rx_vc) == v) && w_full[v];
         w_pop[v]     = w_accept && (int'(r_vc) == v);
      end
   end

   // Two descending passes, last write wins: lowest nonempty VC at/after the
   // RR pointer, otherwise lowest nonempty VC below it.
   always_comb begin
      w_pick_ok = 1'b0;
      w_pick    = '0;
      for (int v = NUM_VC - 1; v >= 0; v--) begin
         if (!w_empty[v] && (v < int'(r_rr))) begin
            w_pick_ok = 1'b1;
            w_pick    = c_VC_W'(v);
         end
      end
      for (int v = NUM_VC - 1; v >= 0; v--) begin
         if (!w_empty[v] && (v >= int'(r_rr))) begin
            w_pick_ok = 1'b1;
            w_pick    = c_VC_W'(v);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_wr_ptr[v] <= '0;
            r_rd_ptr[v] <= '0;
            r_count[v]  <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (w_push[v]) r_wr_ptr[v] <= r_wr_ptr[v] + c_PTR_W'(1);
            if (w_pop[v])  r_rd_ptr[v] <= r_rd_ptr[v] + c_PTR_W'(1);
            if (w_push[v] && !w_pop[v]) begin
               r_count[v] <= r_count[v] + c_CNT_W'(1);
            end else if (!w_push[v] && w_pop[v]) begin
               r_count[v] <= r_count[v] - c_CNT_W'(1);
            end
            if (w_ovf_set[v]) r_ovf[v] <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (w_push[v]) r_mem[v][r_wr_ptr[v]] <= bus.i_data;
      end
   end

   // r_idx: 0 = header next, 1 = size next, 2 = payload with r_rem left.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state  <= S_IDLE;
         r_vc     <= '0;
         r_rr     <= '0;
         r_h      <= 1'b0;
         r_sender <= 1'b0;
         r_idx    <= 2'd0;
         r_rem    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pick_ok) begin
                  r_vc    <= w_pick;
                  r_h     <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.i_ack_h) begin
                  r_h      <= 1'b0;
                  r_sender <= 1'b1;
                  r_idx    <= 2'd0;
                  r_state  <= S_SEND;
               end
            end
            S_SEND: begin
               if (w_last) begin
                  r_sender <= 1'b0;
                  r_state  <= S_IDLE;
                  r_rr     <= (int'(r_vc) == NUM_VC - 1) ? '0 : r_vc + c_VC_W'(1);
               end else if (w_accept) begin
                  if (r_idx == 2'd0) begin
                     r_idx <= 2'd1;
                  end else if (r_idx == 2'd1) begin
                     r_rem <= w_head;
                     r_idx <= 2'd2;
                  end else begin
                     r_rem <= r_rem - FLIT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_credit  = ~w_full;
   assign bus.o_h       = r_h;
   assign bus.o_data_av = w_data_av;
   assign bus.o_data    = w_head;
   assign bus.o_vc      = r_vc;
   assign bus.o_sender  = r_sender;
   assign bus.o_ovf     = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_phoenix_vc_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phoenix_vc_buffer
// Description : Scoreboard bench for phoenix_vc_buffer with per-VC flit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phoenix_vc_buffer;
   localparam int c_DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   phoenix_vc_buffer_if #(.FLIT_W(16), .NUM_VC(2)) bus ();

   phoenix_vc_buffer #(.FLIT_W(16), .DEPTH(c_DEPTH), .NUM_VC(2)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp0[$], exp1[$], pend0[$], pend1[$];
   int          mdl_cnt[2];
   logic [1:0]  mdl_ovf;
   int          vc_log[$];
   bit          in_pkt, chk_release, rand_mode;
   int          pkt_vc, pkt_idx, pkt_rem, mon_v;
   logic [15:0] mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected stream per VC: a flit is expected exactly when the model FIFO has room.
   task automatic step(input bit rx, input int vc, input logic [15:0] d);
      chk("credit", bus.o_credit, {31'd0, mdl_cnt[1] != c_DEPTH} << 1 | (mdl_cnt[0] != c_DEPTH));
      chk("ovf", bus.o_ovf, mdl_ovf);
      bus.i_rx    = rx;
      bus.i_rx_vc = vc[0];
      bus.i_data  = d;
      if (rand_mode) begin
         bus.i_ack_h    = 1'($urandom_range(0, 1));
         bus.i_data_ack = ($urandom_range(0, 3) != 0);
      end
      if (rx) begin
         if (mdl_cnt[vc] < c_DEPTH) begin
            mdl_cnt[vc]++;
            if (vc == 0) exp0.push_back(d);
            else         exp1.push_back(d);
         end else begin
            mdl_ovf[vc] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_flit(input int vc, input logic [15:0] d);
      int guard = 0;
      while (mdl_cnt[vc] >= c_DEPTH && guard < 200) begin
         step(0, 0, 16'h0);
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         failures++;
         $display("FAIL send_wait vc%0d actual=full required=space", vc);
      end else begin
         step(1, vc, d);
      end
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp0.size() != 0 || exp1.size() != 0 || in_pkt) && guard < 1000) begin
         step(0, 0, 16'h0);
         guard++;
      end
      checks++;
      if (guard >= 1000) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d/%0d flits left required=0", exp0.size(), exp1.size());
      end
   endtask

   task automatic wait_h();
      int guard = 0;
      while (!bus.o_h && guard < 50) begin
         step(0, 0, 16'h0);
         guard++;
      end
      chk("wait_h", bus.o_h, 1);
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      bus.i_rx       = 1'b0;
      bus.i_ack_h    = 1'b0;
      bus.i_data_ack = 1'b0;
      exp0.delete();
      exp1.delete();
      mdl_cnt[0]  = 0;
      mdl_cnt[1]  = 0;
      mdl_ovf     = '0;
      in_pkt      = 1'b0;
      chk_release = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_credit", bus.o_credit, 2'b11);
      chk("rst_h", bus.o_h, 0);
      chk("rst_av", bus.o_data_av, 0);
      chk("rst_sender", bus.o_sender, 0);
      chk("rst_vc", bus.o_vc, 0);
      chk("rst_ovf", bus.o_ovf, 0);
      rst = 1'b1;
   endtask

   task automatic gen_pkt(input int vc);
      logic [15:0] f[$];
      int          n = $urandom_range(0, 3);
      f.push_back(16'($urandom));
      f.push_back(16'(n));
      for (int i = 0; i < n; i++) f.push_back(16'($urandom));
      foreach (f[i]) begin
         if (vc == 0) pend0.push_back(f[i]);
         else         pend1.push_back(f[i]);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted flit and tracks packet framing.
   always @(negedge clk) begin
      if (rst) begin
         if (chk_release) begin
            chk("release_sender", bus.o_sender, 0);
            chk_release = 1'b0;
         end
         if (bus.o_data_av) begin
            chk("sender_with_av", bus.o_sender, 1);
            chk("h_while_send", bus.o_h, 0);
            if (bus.i_data_ack) begin
               mon_v = int'(bus.o_vc);
               if ((mon_v == 0 ? exp0.size() : exp1.size()) == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_flit vc%0d actual=%0h required=none", mon_v, bus.o_data);
               end else begin
                  if (mon_v == 0) mon_e = exp0.pop_front();
                  else            mon_e = exp1.pop_front();
                  chk("flit_data", bus.o_data, mon_e);
                  mdl_cnt[mon_v]--;
                  if (!in_pkt) begin
                     in_pkt  = 1'b1;
                     pkt_vc  = mon_v;
                     pkt_idx = 1;
                     vc_log.push_back(mon_v);
                  end else begin
                     chk("no_interleave", mon_v, pkt_vc);
                     if (pkt_idx == 1) begin
                        pkt_rem = int'(bus.o_data);
                        pkt_idx = 2;
                     end else begin
                        pkt_rem--;
                     end
                     if (pkt_rem == 0) begin
                        in_pkt      = 1'b0;
                        chk_release = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] seq[4];
      bit          drop, saw0, saw1;
      int          guard;
      bus.i_rx = 1'b0; bus.i_rx_vc = '0; bus.i_data = '0;
      bus.i_ack_h = 1'b0; bus.i_data_ack = 1'b0;
      rand_mode = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         chk("idle_h", bus.o_h, 0);
         chk("idle_av", bus.o_data_av, 0);
         step(0, 0, 16'h0);
      end

      // Single packet, grant delayed 3 cycles, crossbar always ready
      seq = '{16'h0101, 16'h0002, 16'hAAAA, 16'hBBBB};
      bus.i_data_ack = 1'b1;
      for (int i = 0; i < 4; i++) step(1, 0, seq[i]);
      wait_h();
      chk("req_vc", bus.o_vc, 0);
      chk("req_header", bus.o_data, 16'h0101);
      for (int i = 0; i < 3; i++) begin
         chk("h_held", bus.o_h, 1);
         step(0, 0, 16'h0);
      end
      bus.i_ack_h = 1'b1;
      step(0, 0, 16'h0);
      bus.i_ack_h = 1'b0;
      chk("h_after_grant", bus.o_h, 0);
      for (int k = 0; k < 4; k++) begin
         chk("seq_av", bus.o_data_av, 1);
         chk("seq_data", bus.o_data, seq[k]);
         step(0, 0, 16'h0);
      end
      chk("seq_done_sender", bus.o_sender, 0);
      chk("seq_done_h", bus.o_h, 0);

      // Round-robin: VC0, VC1, then VC0 again
      vc_log.delete();
      bus.i_ack_h = 1'b1;
      send_flit(0, 16'h0A00); send_flit(1, 16'h0B00);
      send_flit(0, 16'h0001); send_flit(1, 16'h0001);
      send_flit(0, 16'h0A01); send_flit(1, 16'h0B01);
      send_flit(0, 16'h0C00); send_flit(0, 16'h0001); send_flit(0, 16'h0C01);
      drain();
      chk("rr_count", vc_log.size(), 3);
      if (vc_log.size() == 3) begin
         chk("rr_first", vc_log[0], 0);
         chk("rr_second", vc_log[1], 1);
         chk("rr_third", vc_log[2], 0);
      end

      // Overflow on VC1 with no grant
      bus.i_ack_h = 1'b0;
      step(1, 1, 16'h1111); step(1, 1, 16'h0002);
      step(1, 1, 16'h2222); step(1, 1, 16'h3333);
      chk("credit1_full", bus.o_credit[1], 0);
      step(1, 1, 16'h4444);
      step(0, 0, 16'h0);
      chk("ovf1_set", bus.o_ovf, 2'b10);
      chk("credit1_still_full", bus.o_credit[1], 0);
      bus.i_ack_h = 1'b1;
      drain();
      step(0, 0, 16'h0);
      chk("credit_after_drain", bus.o_credit, 2'b11);

      // Full VC0 pushed while its head is being popped: the push is dropped
      bus.i_ack_h = 1'b0;
      step(1, 0, 16'h5000); step(1, 0, 16'h0003);
      step(1, 0, 16'h5001); step(1, 0, 16'h5002);
      bus.i_ack_h = 1'b1;
      guard = 0;
      while (!bus.o_data_av && guard < 20) begin step(0, 0, 16'h0); guard++; end
      chk("full_pop_av", bus.o_data_av, 1);
      step(1, 0, 16'h5003);
      send_flit(0, 16'h5004);
      drain();
      chk("ovf0_set", bus.o_ovf[0], 1);

      // Randomized traffic and handshakes
      rand_mode = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         int v = $urandom_range(0, 1);
         if (pend0.size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(0);
         if (pend1.size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(1);
         if (v == 0 && pend0.size() != 0 && mdl_cnt[0] < c_DEPTH && $urandom_range(0, 2) != 0)
            step(1, 0, pend0.pop_front());
         else if (v == 1 && pend1.size() != 0 && mdl_cnt[1] < c_DEPTH && $urandom_range(0, 2) != 0)
            step(1, 1, pend1.pop_front());
         else
            step(0, int'($urandom_range(0, 1)), 16'($urandom));
      end
      while (pend0.size() != 0) send_flit(0, pend0.pop_front());
      while (pend1.size() != 0) send_flit(1, pend1.pop_front());
      rand_mode = 1'b0;
      bus.i_ack_h = 1'b1;
      bus.i_data_ack = 1'b1;
      drain();

      // Slow payload: bubbles keep the VC owner, then reset mid-packet
      step(1, 0, 16'h7000); step(1, 0, 16'h0003);
      guard = 0;
      while (!bus.o_sender && guard < 20) begin step(0, 0, 16'h0); guard++; end
      drop = 1'b0; saw0 = 1'b0; saw1 = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int t = 0; t < 4; t++) begin
            if (!bus.o_sender) drop = 1'b1;
            if (bus.o_data_av) saw1 = 1'b1;
            else               saw0 = 1'b1;
            if (t == 0) step(1, 0, 16'h7001 + 16'(p));
            else        step(0, 0, 16'h0);
         end
      end
      chk("slow_sender_held", drop, 0);
      chk("slow_av_low_seen", saw0, 1);
      chk("slow_av_high_seen", saw1, 1);
      do_reset();
      bus.i_ack_h = 1'b1;
      bus.i_data_ack = 1'b1;
      step(1, 0, 16'h7100); step(1, 0, 16'h0000);
      drain();
      step(0, 0, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
